msg_block_segmenter: RTL and testbench

Upstream producer for the encoder's stored-message buffer. Accepts the information bits of one code block as a valid/ready stream of IN_W-bit words, packs them into Zc-bit lifted columns and emits one column per pulse on `segmented_msg_block` / `new_seg_msg_block` / `current_col`, in column order 0..Kb-1. It is the writing end of the message-column interface that the stored-message selector reads.

---
 rtl/LDPC_pkg.sv | 33 +++
 rtl/seg_bit_accumulator.sv | 72 +++++++
 rtl/msg_block_segmenter.sv | 106 ++++++++++
 tb/tb_msg_block_segmenter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/LDPC_pkg.sv
// Shared LDPC encoder types and constants: lifting-size bounds, base-graph
// selector and the message column counts per base graph.
package LDPC_pkg;

  localparam int MAX_ZC            = 384;
  localparam int ZC_W              = 9;
  localparam int COL_W             = 5;
  localparam int BG1_MSG_COL_COUNT = 22;
  localparam int BG2_MSG_COL_COUNT = 10;

  typedef enum logic {
    BG1 = 1'b0,
    BG2 = 1'b1
  } BG_Type;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } seg_state_e;

  // Lifting sizes below 2 or above MAX_ZC are not meaningful; pin them to the range.
  function automatic logic [ZC_W-1:0] clamp_zc(input logic [ZC_W-1:0] z);
    if (z < ZC_W'(2))      return ZC_W'(2);
    if (z > ZC_W'(MAX_ZC)) return ZC_W'(MAX_ZC);
    return z;
  endfunction

  function automatic logic [COL_W-1:0] kb_of(input BG_Type bg);
    return (bg == BG1) ? COL_W'(BG1_MSG_COL_COUNT) : COL_W'(BG2_MSG_COL_COUNT);
  endfunction

endpackage

// File: rtl/seg_bit_accumulator.sv
// Bit packer: moves up to IN_W bits per cycle from the residue or the input word
// into a zc_r-bit column, keeping any overflow bits in the residue.
module seg_bit_accumulator
  import LDPC_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              force_close,
  input  logic [ZC_W-1:0]   zc_r,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_take,
  output logic              res_empty,
  output logic              col_done,
  output logic [MAX_ZC-1:0] col_data
);

  localparam int CW = $clog2(IN_W + 1);
  localparam logic [IN_W:0] ONE = (IN_W + 1)'(1);

  logic [MAX_ZC-1:0] acc, acc_nxt;
  logic [ZC_W-1:0]   fill, fill_nxt, room;
  logic [IN_W-1:0]   res, res_nxt, src, src_m;
  logic [CW-1:0]     res_cnt, res_cnt_nxt, avail, n;
  logic [IN_W:0]     mask;

  always_comb begin
    res_empty   = (res_cnt == '0);
    // Leftover bits always drain before a new word is taken.
    src         = res_empty ? in_data : res;
    avail       = !res_empty ? res_cnt : (in_take ? CW'(IN_W) : '0);
    room        = zc_r - fill;
    n           = (ZC_W'(avail) > room) ? CW'(room) : avail;
    mask        = (ONE << n) - ONE;
    src_m       = src & mask[IN_W-1:0];
    acc_nxt     = acc | (MAX_ZC'(src_m) << fill);
    fill_nxt    = fill + ZC_W'(n);
    res_nxt     = src >> n;
    res_cnt_nxt = avail - n;
    // force_close emits the partially filled (zero-padded) column once the residue is gone.
    col_done    = en && ((fill_nxt == zc_r) || (force_close && (res_cnt_nxt == '0)));
    col_data    = acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      fill    <= '0;
      res     <= '0;
      res_cnt <= '0;
    end else if (clear) begin
      acc     <= '0;
      fill    <= '0;
      res     <= '0;
      res_cnt <= '0;
    end else if (en) begin
      res     <= res_nxt;
      res_cnt <= res_cnt_nxt;
      if (col_done) begin
        acc  <= '0;
        fill <= '0;
      end else begin
        acc  <= acc_nxt;
        fill <= fill_nxt;
      end
    end
  end

endmodule

// File: rtl/msg_block_segmenter.sv
// Packs a code block's message stream into Zc-bit columns 0..Kb-1 for the encoder.
// Define MSG_SEG_LAST_PAD_EN to let in_last end the input early with zero-padded columns.
module msg_block_segmenter
  import LDPC_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  BG_Type            BG,
  input  logic [ZC_W-1:0]   zc,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [MAX_ZC-1:0] segmented_msg_block,
  output logic              new_seg_msg_block,
  output logic [COL_W-1:0]  current_col,
  output logic              msg_done,
  output logic              busy
);

  seg_state_e        state;
  logic [ZC_W-1:0]   zc_r;
  logic [COL_W-1:0]  kb_r, col_cnt;
  logic              last_done, pad_r;
  logic              res_empty, col_done, take, acc_clear, acc_en;
  logic [MAX_ZC-1:0] col_data;

  // last_done marks that column Kb-1 has been produced; nothing more is accepted.
  assign in_ready  = (state == S_FILL) && res_empty && !last_done && !pad_r;
  assign busy      = (state != S_IDLE);
  assign take      = in_valid && in_ready;
  assign acc_clear = ((state == S_IDLE) && start) || (state == S_DONE);
  assign acc_en    = (state == S_FILL) && !last_done;

  seg_bit_accumulator #(.IN_W(IN_W)) u_acc (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear      (acc_clear),
    .en         (acc_en),
    .force_close(pad_r),
    .zc_r       (zc_r),
    .in_data    (in_data),
    .in_take    (take),
    .res_empty  (res_empty),
    .col_done   (col_done),
    .col_data   (col_data)
  );

`ifdef MSG_SEG_LAST_PAD_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         pad_r <= 1'b0;
    else if (acc_clear)   pad_r <= 1'b0;
    else if (take && in_last) pad_r <= 1'b1;
  end
`else
  logic unused_in_last;
  assign pad_r          = 1'b0;
  assign unused_in_last = in_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      zc_r                <= ZC_W'(2);
      kb_r                <= '0;
      col_cnt             <= '0;
      last_done           <= 1'b0;
      segmented_msg_block <= '0;
      new_seg_msg_block   <= 1'b0;
      current_col         <= '0;
      msg_done            <= 1'b0;
    end else begin
      new_seg_msg_block <= 1'b0;
      msg_done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FILL;
            zc_r      <= clamp_zc(zc);
            kb_r      <= kb_of(BG);
            col_cnt   <= '0;
            last_done <= 1'b0;
          end
        end
        S_FILL: begin
          if (last_done) begin
            state    <= S_DONE;
            msg_done <= 1'b1;
          end else if (col_done) begin
            segmented_msg_block <= col_data;
            new_seg_msg_block   <= 1'b1;
            current_col         <= col_cnt;
            col_cnt             <= col_cnt + COL_W'(1);
            if (col_cnt == kb_r - COL_W'(1)) last_done <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_block_segmenter.sv
// Randomized self-checking bench for msg_block_segmenter against a bit-stream column model.
module tb_msg_block_segmenter;
  import LDPC_pkg::*;

  localparam int IN_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  BG_Type            BG = BG1;
  logic [8:0]        zc = '0;
  logic [IN_W-1:0]   in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [MAX_ZC-1:0] segmented_msg_block;
  logic              new_seg_msg_block;
  logic [4:0]        current_col;
  logic              msg_done;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  typedef struct {
    int                col;
    logic [MAX_ZC-1:0] data;
    int                cyc;
  } pulse_t;

  pulse_t          pulse_q[$];
  logic [IN_W-1:0] words[$];
  int              acc_cyc[$];
  int              start_cyc;
  logic            start_busy, start_rdy, post_busy;
  bit              timed_out;

  msg_block_segmenter #(.IN_W(IN_W)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .BG                 (BG),
    .zc                 (zc),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_last            (in_last),
    .segmented_msg_block(segmented_msg_block),
    .new_seg_msg_block  (new_seg_msg_block),
    .current_col        (current_col),
    .msg_done           (msg_done),
    .busy               (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (new_seg_msg_block) pulse_q.push_back('{int'(current_col), segmented_msg_block, cyc});
    if (msg_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: column c is bits [c*z, c*z+z) of the concatenated word stream, zero past the end.
  function automatic logic [MAX_ZC-1:0] exp_col(input int c, input int z);
    logic [MAX_ZC-1:0] r;
    r = '0;
    for (int i = 0; i < z; i++) begin
      int b;
      int w;
      b = c * z + i;
      w = b / IN_W;
      if (w < words.size()) r[i] = words[w][b % IN_W];
    end
    return r;
  endfunction

  function automatic int clampi(input int z);
    return (z < 2) ? 2 : ((z > MAX_ZC) ? MAX_ZC : z);
  endfunction

  task automatic run_block(input BG_Type bg, input int zcv, input int last_at, input int vprob,
                           input bit poke, input int abort_at);
    int idx;
    int guard;
    int d0;
    idx = 0;
    guard = 0;
    pulse_q.delete();
    acc_cyc.delete();
    timed_out = 1'b0;
    d0 = done_cnt;
    BG = bg;
    zc = 9'(zcv);
    start = 1'b1;
    start_cyc = cyc;
    step;
    start = 1'b0;
    start_busy = busy;
    start_rdy = in_ready;
    while (done_cnt == d0) begin
      if (abort_at > 0 && pulse_q.size() >= abort_at) break;
      if (guard >= 20000) begin
        timed_out = 1'b1;
        break;
      end
      in_valid = (idx < words.size()) && (int'($urandom_range(99)) < vprob);
      in_data  = in_valid ? words[idx] : IN_W'($urandom);
      in_last  = in_valid && (idx == last_at);
      BG       = BG_Type'($urandom_range(1));
      zc       = 9'($urandom);
      start    = poke && (guard == 5);
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        idx++;
      end
      step;
      guard++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
    post_busy = busy;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) step;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (new_seg_msg_block !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", new_seg_msg_block); end
    checks++; if (msg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", msg_done); end
    checks++; if (current_col !== 5'd0) begin errors++; $display("FAIL reset_col got %0d want 0", current_col); end
    checks++; if (segmented_msg_block !== '0) begin errors++; $display("FAIL reset_data got %h want 0", segmented_msg_block); end
    reset_n = 1'b1;
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_full_rate;
    int stalls;
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 16, -1, 100, 1'b0, 0);
    checks++; if (timed_out) begin errors++; $display("FAIL fr_timeout got timeout want msg_done"); end
    checks++; if (start_busy !== 1'b1) begin errors++; $display("FAIL fr_start_busy got %b want 1", start_busy); end
    checks++; if (start_rdy !== 1'b1) begin errors++; $display("FAIL fr_start_ready got %b want 1", start_rdy); end
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL fr_count got %0d want 10", pulse_q.size()); end
    for (int i = 0; i < pulse_q.size(); i++) begin
      checks++;
      if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, 16)) begin
        errors++;
        $display("FAIL fr_col%0d got col %0d data %h want col %0d data %h", i, pulse_q[i].col,
                 pulse_q[i].data[15:0], i, exp_col(i, 16) & 384'hFFFF);
      end
      if (i > 0) begin
        checks++;
        if (pulse_q[i].cyc - pulse_q[i-1].cyc != 2) begin
          errors++; $display("FAIL fr_spacing%0d got %0d want 2", i, pulse_q[i].cyc - pulse_q[i-1].cyc);
        end
      end
    end
    stalls = 0;
    for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 1) stalls++;
    checks++; if (stalls != 0 || acc_cyc.size() != 20) begin errors++; $display("FAIL fr_stalls got %0d stalls %0d words want 0 stalls 20 words", stalls, acc_cyc.size()); end
    if (acc_cyc.size() > 1 && pulse_q.size() > 0) begin
      checks++;
      if (pulse_q[0].cyc != acc_cyc[1] + 1) begin errors++; $display("FAIL fr_latency got %0d want %0d", pulse_q[0].cyc, acc_cyc[1] + 1); end
    end
    if (pulse_q.size() > 0) begin
      checks++;
      if (done_cyc != pulse_q[$].cyc + 1) begin errors++; $display("FAIL fr_done got %0d want %0d", done_cyc, pulse_q[$].cyc + 1); end
    end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL fr_busy_after got %b want 0", post_busy); end
  endtask

  task automatic test_straddle;
    int bad;
    words.delete();
    words.push_back(8'hFF);
    words.push_back(8'hAB);
    for (int i = 2; i < 15; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 12, -1, 100, 1'b0, 0);
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL st_count got %0d want 10", pulse_q.size()); end
    if (pulse_q.size() > 1) begin
      checks++; if (pulse_q[0].data !== 384'hBFF) begin errors++; $display("FAIL st_col0 got %h want bff", pulse_q[0].data[11:0]); end
      checks++; if (pulse_q[1].data[3:0] !== 4'hA) begin errors++; $display("FAIL st_col1_lo got %h want a", pulse_q[1].data[3:0]); end
    end
    if (acc_cyc.size() > 2) begin
      checks++;
      if (acc_cyc[2] - acc_cyc[1] != 2) begin errors++; $display("FAIL st_stall got %0d want 2", acc_cyc[2] - acc_cyc[1]); end
    end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, 12)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL st_columns got %0d bad want 0", bad); end
  endtask

  task automatic test_small_zc;
    logic [MAX_ZC-1:0] want;
    words.delete();
    words.push_back(8'hE4);
    words.push_back(IN_W'($urandom));
    words.push_back(IN_W'($urandom));
    run_block(BG2, 2, -1, 100, 1'b0, 0);
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL sz_count got %0d want 10", pulse_q.size()); end
    for (int i = 0; i < 4 && i < pulse_q.size(); i++) begin
      want = MAX_ZC'(i);
      checks++;
      if (pulse_q[i].data !== want) begin errors++; $display("FAIL sz_col%0d got %h want %h", i, pulse_q[i].data[1:0], want[1:0]); end
      if (i > 0) begin
        checks++;
        if (pulse_q[i].cyc - pulse_q[i-1].cyc != 1) begin errors++; $display("FAIL sz_consec%0d got %0d want 1", i, pulse_q[i].cyc - pulse_q[i-1].cyc); end
      end
    end
    if (acc_cyc.size() > 1) begin
      checks++;
      if (acc_cyc[1] - acc_cyc[0] != 4) begin errors++; $display("FAIL sz_stall got %0d want 4", acc_cyc[1] - acc_cyc[0]); end
    end
  endtask

  task automatic test_reset_mid;
    int hi_busy;
    int hi_rdy;
    int bad;
    words.delete();
    for (int i = 0; i < 1056; i++) words.push_back(IN_W'($urandom));
    run_block(BG1, 384, -1, 100, 1'b0, 6);
    checks++; if (pulse_q.size() < 6) begin errors++; $display("FAIL rm_progress got %0d want 6", pulse_q.size()); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || new_seg_msg_block !== 1'b0 || msg_done !== 1'b0 ||
        current_col !== 5'd0 || segmented_msg_block !== '0) begin
      errors++;
      $display("FAIL rm_outputs got busy %b rdy %b pulse %b done %b col %0d want all 0",
               busy, in_ready, new_seg_msg_block, msg_done, current_col);
    end
    step;
    reset_n = 1'b1;
    pulse_q.delete();
    hi_busy = 0;
    hi_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data = IN_W'($urandom);
      step;
      if (busy) hi_busy++;
      if (in_ready) hi_rdy++;
    end
    in_valid = 1'b0;
    checks++; if (pulse_q.size() != 0) begin errors++; $display("FAIL rm_pulses got %0d want 0", pulse_q.size()); end
    checks++; if (hi_busy != 0 || hi_rdy != 0) begin errors++; $display("FAIL rm_idle got busy %0d ready %0d want 0 0", hi_busy, hi_rdy); end
    // A second start mid-block must not disturb geometry or column count.
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 16, -1, 70, 1'b1, 0);
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL rm_restart_count got %0d want 10", pulse_q.size()); end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, 16)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rm_restart_cols got %0d bad want 0", bad); end
  endtask

  task automatic test_clamp;
    int bad;
    words.delete();
    for (int i = 0; i < 6; i++) words.push_back(IN_W'($urandom));
    run_block(BG1, 0, -1, 100, 1'b0, 0);
    checks++; if (pulse_q.size() != 22) begin errors++; $display("FAIL cl_lo_count got %0d want 22", pulse_q.size()); end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, 2)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL cl_lo_cols got %0d bad want 0", bad); end
    words.delete();
    for (int i = 0; i < 480; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 450, -1, 100, 1'b0, 0);
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL cl_hi_count got %0d want 10", pulse_q.size()); end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].data !== exp_col(i, clampi(450))) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL cl_hi_cols got %0d bad want 0", bad); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      BG_Type b;
      int z;
      int kb;
      int nw;
      int la;
      int bad;
      b = BG_Type'($urandom_range(1));
      z = $urandom_range(2, 50);
      kb = (b == BG1) ? 22 : 10;
      nw = (kb * z + IN_W - 1) / IN_W;
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back(IN_W'($urandom));
`ifdef MSG_SEG_LAST_PAD_EN
      la = -1;
`else
      la = $urandom_range(nw - 1);
`endif
      run_block(b, z, la, $urandom_range(30, 100), 1'b0, 0);
      checks++; if (timed_out || pulse_q.size() != kb) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", it, pulse_q.size(), kb); end
      bad = 0;
      for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, z)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_cols got %0d bad want 0 (zc %0d)", it, bad, z); end
      if (pulse_q.size() > 0) begin
        checks++;
        if (done_cyc != pulse_q[$].cyc + 1) begin errors++; $display("FAIL rnd%0d_done got %0d want %0d", it, done_cyc, pulse_q[$].cyc + 1); end
      end
    end
  endtask

  task automatic test_last;
    int bad;
    words.delete();
`ifdef MSG_SEG_LAST_PAD_EN
    for (int i = 0; i < 4; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 16, 3, 100, 1'b0, 0);
    checks++; if (pulse_q.size() != 10) begin errors++; $display("FAIL pad_count got %0d want 10", pulse_q.size()); end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) begin
      if (pulse_q[i].col != i || pulse_q[i].data !== exp_col(i, 16)) bad++;
      if (i >= 2 && pulse_q[i].cyc - pulse_q[i-1].cyc != 1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL pad_cols got %0d bad want 0", bad); end
    if (pulse_q.size() > 0) begin
      checks++;
      if (done_cyc != pulse_q[$].cyc + 1) begin errors++; $display("FAIL pad_done got %0d want %0d", done_cyc, pulse_q[$].cyc + 1); end
    end
`else
    for (int i = 0; i < 20; i++) words.push_back(IN_W'($urandom));
    run_block(BG2, 16, 3, 100, 1'b0, 0);
    checks++; if (acc_cyc.size() != 20) begin errors++; $display("FAIL last_ignored_words got %0d want 20", acc_cyc.size()); end
    bad = 0;
    for (int i = 0; i < pulse_q.size(); i++) if (pulse_q[i].data !== exp_col(i, 16)) bad++;
    checks++; if (bad != 0 || pulse_q.size() != 10) begin errors++; $display("FAIL last_ignored_cols got %0d bad %0d pulses want 0 10", bad, pulse_q.size()); end
`endif
  endtask

  initial begin
    test_reset();
    test_full_rate();
    test_straddle();
    test_small_zc();
    test_reset_mid();
    test_clamp();
    test_random();
    test_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
